// File: rtl/bus_transfer_sequencer.sv
// Sequences one register->register or immediate->register move on the shared
// 8-bit bus, owning every register read/write enable so only one driver and one writer are ever active.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [SEL_W-1:0]    i_cmd_src,
  input  logic [SEL_W-1:0]    i_cmd_dst,
  input  logic                i_cmd_imm_en,
  input  logic [7:0]          i_cmd_imm,
  output logic [NUM_REGS-1:0] o_read_n,
  output logic [NUM_REGS-1:0] o_write_n,
  inout  wire  [7:0]          io_bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [SEL_W:0] LP_NUM_REGS = (SEL_W+1)'(NUM_REGS);

  state_t              r_state;
  logic [SEL_W-1:0]    r_src;
  logic [SEL_W-1:0]    r_dst;
  logic                r_imm_en;
  logic [7:0]          r_imm;
  logic [NUM_REGS-1:0] r_read_n;
  logic [NUM_REGS-1:0] r_write_n;
  logic                r_bus_oe;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  state_t              w_next_state;
  logic                w_accept;
  logic                w_illegal;
  logic [SEL_W-1:0]    w_src;
  logic [SEL_W-1:0]    w_dst;
  logic                w_imm_en;
  logic [7:0]          w_imm;
  logic [NUM_REGS-1:0] w_read_n;
  logic [NUM_REGS-1:0] w_write_n;
  logic                w_bus_oe;

  // Handshake: a command transfers on a rising edge where i_cmd_valid and
  // o_cmd_ready are both high; ready is high only in IDLE/DONE/ERR and never in reset.
  assign o_cmd_ready = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR))
                       && !i_reset;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_illegal   = ({1'b0, i_cmd_dst} >= LP_NUM_REGS) ||
                       (!i_cmd_imm_en && (({1'b0, i_cmd_src} >= LP_NUM_REGS) ||
                                          (i_cmd_src == i_cmd_dst)));

  always_comb begin
    w_src        = r_src;
    w_dst        = r_dst;
    w_imm_en     = r_imm_en;
    w_imm        = r_imm;
    w_next_state = r_state;
    if (w_accept) begin
      w_src    = i_cmd_src;
      w_dst    = i_cmd_dst;
      w_imm_en = i_cmd_imm_en;
      w_imm    = i_cmd_imm;
    end
    case (r_state)
      S_SETUP: w_next_state = S_XFER;
      S_XFER:  w_next_state = S_DONE;
      default: begin
        if (w_accept) w_next_state = w_illegal ? S_ERR : S_SETUP;
        else          w_next_state = S_IDLE;
      end
    endcase
  end

  // Strobes are computed for the state being entered so they come straight out of flops.
  always_comb begin
    w_read_n  = '1;
    w_write_n = '1;
    w_bus_oe  = 1'b0;
    if ((w_next_state == S_SETUP) || (w_next_state == S_XFER)) begin
      if (w_imm_en) begin
        w_bus_oe = 1'b1;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_src == SEL_W'(i)) w_read_n[i] = 1'b0;
        end
      end
    end
    if (w_next_state == S_XFER) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_dst == SEL_W'(i)) w_write_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_imm_en  <= 1'b0;
      r_imm     <= '0;
      r_read_n  <= '1;
      r_write_n <= '1;
      r_bus_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_src     <= w_src;
      r_dst     <= w_dst;
      r_imm_en  <= w_imm_en;
      r_imm     <= w_imm;
      r_read_n  <= w_read_n;
      r_write_n <= w_write_n;
      r_bus_oe  <= w_bus_oe;
      r_busy    <= (w_next_state == S_SETUP) || (w_next_state == S_XFER);
      r_done    <= (w_next_state == S_DONE);
      r_error   <= (w_next_state == S_ERR);
    end
  end

  assign io_bus      = r_bus_oe ? r_imm : 8'hzz;
  assign o_read_n    = r_read_n;
  assign o_write_n   = r_write_n;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer: models four bus registers around
// the main instance and uses a second, three-register instance for range rejection.
module tb_bus_transfer_sequencer;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       cmd_valid;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic       cmd_imm_en;
  logic [7:0] cmd_imm;
  logic       cmd_ready;
  logic [3:0] read_n;
  logic [3:0] write_n;
  wire  [7:0] w_bus;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] dbg_state;

  logic       valid3;
  logic [1:0] src3;
  logic [1:0] dst3;
  logic       imm_en3;
  logic       ready3;
  logic [2:0] read_n3;
  logic [2:0] write_n3;
  wire  [7:0] w_bus3;
  logic       busy3;
  logic       done3;
  logic       error3;
  logic [2:0] dbg_state3;

  logic [7:0] regs [4];
  logic       pl_en;
  logic [1:0] pl_idx;
  logic [7:0] pl_val;
  logic       drv_en;
  logic [7:0] drv_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_transfer_sequencer #(.NUM_REGS(4), .SEL_W(2)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst), .i_cmd_imm_en(cmd_imm_en), .i_cmd_imm(cmd_imm),
    .o_read_n(read_n), .o_write_n(write_n), .io_bus(w_bus), .o_busy(busy),
    .o_done(done), .o_error(error), .o_dbg_state(dbg_state)
  );

  bus_transfer_sequencer #(.NUM_REGS(3), .SEL_W(2)) dut3 (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(valid3), .o_cmd_ready(ready3),
    .i_cmd_src(src3), .i_cmd_dst(dst3), .i_cmd_imm_en(imm_en3), .i_cmd_imm(8'h42),
    .o_read_n(read_n3), .o_write_n(write_n3), .io_bus(w_bus3), .o_busy(busy3),
    .o_done(done3), .o_error(error3), .o_dbg_state(dbg_state3)
  );

  // Idle bus reads as 0x00, so any stray drive by the sequencer shows up.
  for (genvar b = 0; b < 8; b++) begin : g_pull
    pulldown pd_main (w_bus[b]);
    pulldown pd_three (w_bus3[b]);
  end

  always_comb begin
    drv_en  = 1'b0;
    drv_val = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (!read_n[i]) begin
        drv_en  = 1'b1;
        drv_val = regs[i];
      end
    end
  end
  assign w_bus = drv_en ? drv_val : 8'hzz;

  always @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    for (int i = 0; i < 4; i++) begin
      if (!write_n[i]) regs[i] <= w_bus;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] idx, input logic [7:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", cmd_ready); end
    checks++; if (read_n !== 4'b1111 || write_n !== 4'b1111) begin failures++; $display("FAIL reset_strobes got=%b/%b want=1111/1111", read_n, write_n); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {busy, done, error}); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    checks++; if (w_bus !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h want=00", w_bus); end
    i_reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || ready3 !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b%b want=11", cmd_ready, ready3); end
  endtask

  task automatic test_reg_move();
    preload(2'd1, 8'h5A);
    preload(2'd2, 8'h00);
    cmd_valid = 1'b1; cmd_src = 2'd1; cmd_dst = 2'd2; cmd_imm_en = 1'b0; cmd_imm = 8'hFF;
    tick();
    cmd_valid = 1'b0; cmd_src = 2'd3; cmd_dst = 2'd0;
    checks++; if (read_n !== 4'b1101 || write_n !== 4'b1111 || busy !== 1'b1) begin failures++; $display("FAIL move_setup got=%b/%b busy=%b want=1101/1111 busy=1", read_n, write_n, busy); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL move_setup_ready got=%b want=0", cmd_ready); end
    tick();
    checks++; if (read_n !== 4'b1101 || write_n !== 4'b1011) begin failures++; $display("FAIL move_xfer got=%b/%b want=1101/1011", read_n, write_n); end
    checks++; if (w_bus !== 8'h5A) begin failures++; $display("FAIL move_xfer_bus got=%h want=5a", w_bus); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || read_n !== 4'b1111 || write_n !== 4'b1111) begin failures++; $display("FAIL move_done got=done%b busy%b %b/%b want=done1 busy0 1111/1111", done, busy, read_n, write_n); end
    checks++; if (regs[2] !== 8'h5A || regs[1] !== 8'h5A) begin failures++; $display("FAIL move_regs got=r1 %h r2 %h want=r1 5a r2 5a", regs[1], regs[2]); end
    tick();
    checks++; if (done !== 1'b0 || dbg_state !== 3'd0) begin failures++; $display("FAIL move_idle got=done%b st%0d want=done0 st0", done, dbg_state); end
  endtask

  task automatic test_immediate();
    cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'hC3;
    tick();
    cmd_valid = 1'b0; cmd_imm = 8'h00;
    checks++; if (w_bus !== 8'hC3 || read_n !== 4'b1111 || write_n !== 4'b1111) begin failures++; $display("FAIL imm_setup got=bus %h %b/%b want=bus c3 1111/1111", w_bus, read_n, write_n); end
    tick();
    checks++; if (w_bus !== 8'hC3 || read_n !== 4'b1111 || write_n !== 4'b1110) begin failures++; $display("FAIL imm_xfer got=bus %h %b/%b want=bus c3 1111/1110", w_bus, read_n, write_n); end
    tick();
    checks++; if (w_bus !== 8'h00 || done !== 1'b1) begin failures++; $display("FAIL imm_done got=bus %h done %b want=bus 00 done 1", w_bus, done); end
    checks++; if (regs[0] !== 8'hC3) begin failures++; $display("FAIL imm_r0 got=%h want=c3", regs[0]); end
    tick();
  endtask

  task automatic test_illegal();
    cmd_valid = 1'b1; cmd_src = 2'd3; cmd_dst = 2'd3; cmd_imm_en = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checks++; if (error !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL illegal_err got=err%b busy%b rdy%b want=err1 busy0 rdy1", error, busy, cmd_ready); end
    checks++; if (read_n !== 4'b1111 || write_n !== 4'b1111) begin failures++; $display("FAIL illegal_strobes got=%b/%b want=1111/1111", read_n, write_n); end
    tick();
    checks++; if (error !== 1'b0 || busy !== 1'b0 || read_n !== 4'b1111 || write_n !== 4'b1111) begin failures++; $display("FAIL illegal_after got=err%b busy%b %b/%b want=err0 busy0 1111/1111", error, busy, read_n, write_n); end
    valid3 = 1'b1; src3 = 2'd0; dst3 = 2'd3; imm_en3 = 1'b1;
    tick();
    valid3 = 1'b0;
    checks++; if (error3 !== 1'b1 || busy3 !== 1'b0) begin failures++; $display("FAIL range3_err got=err%b busy%b want=err1 busy0", error3, busy3); end
    valid3 = 1'b1; src3 = 2'd0; dst3 = 2'd2; imm_en3 = 1'b0;
    tick();
    valid3 = 1'b0;
    checks++; if (error3 !== 1'b0 || busy3 !== 1'b1 || read_n3 !== 3'b110) begin failures++; $display("FAIL range3_legal got=err%b busy%b rd%b want=err0 busy1 rd110", error3, busy3, read_n3); end
    tick();
    checks++; if (write_n3 !== 3'b011) begin failures++; $display("FAIL range3_xfer got=%b want=011", write_n3); end
    tick();
    checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL range3_done got=%b want=1", done3); end
    tick();
  endtask

  task automatic test_back_to_back();
    preload(2'd0, 8'h77);
    cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_imm_en = 1'b0; cmd_imm = 8'h00;
    tick();
    cmd_src = 2'd2; cmd_dst = 2'd3; cmd_imm_en = 1'b1; cmd_imm = 8'h11;
    tick();
    tick();
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=done%b rdy%b want=done1 rdy1", done, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || w_bus !== 8'h11) begin failures++; $display("FAIL b2b_setup2 got=busy%b done%b bus %h want=busy1 done0 bus 11", busy, done, w_bus); end
    tick();
    checks++; if (done !== 1'b0 || write_n !== 4'b0111) begin failures++; $display("FAIL b2b_xfer2 got=done%b wr%b want=done0 wr0111", done, write_n); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b want=1", done); end
    checks++; if (regs[1] !== 8'h77 || regs[3] !== 8'h11) begin failures++; $display("FAIL b2b_regs got=r1 %h r3 %h want=r1 77 r3 11", regs[1], regs[3]); end
    tick();
  endtask

  task automatic test_reset_mid_xfer();
    cmd_valid = 1'b1; cmd_src = 2'd1; cmd_dst = 2'd3; cmd_imm_en = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (write_n !== 4'b0111) begin failures++; $display("FAIL rstx_in_xfer got=%b want=0111", write_n); end
    i_reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rstx_ready got=%b want=0", cmd_ready); end
    tick();
    i_reset = 1'b0;
    #1;
    checks++; if (read_n !== 4'b1111 || write_n !== 4'b1111 || w_bus !== 8'h00) begin failures++; $display("FAIL rstx_strobes got=%b/%b bus %h want=1111/1111 bus 00", read_n, write_n, w_bus); end
    checks++; if (done !== 1'b0 || dbg_state !== 3'd0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstx_state got=done%b st%0d rdy%b want=done0 st0 rdy1", done, dbg_state, cmd_ready); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstx_no_done got=%b want=0", done); end
  endtask

  task automatic test_invariants();
    int bad;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_src    = 2'($urandom_range(0, 3));
      cmd_dst    = 2'($urandom_range(0, 3));
      cmd_imm_en = 1'($urandom_range(0, 1));
      cmd_imm    = 8'($urandom_range(1, 255));
      tick();
      checks++;
      if ($countones(~read_n) > 1 || $countones(~write_n) > 1 ||
          (drv_en && w_bus !== drv_val)) begin
        failures++;
        if (bad < 5) $display("FAIL invariant cycle=%0d got=rd%b wr%b bus %h want=one-hot-or-none bus %h", c, read_n, write_n, w_bus, drv_val);
        bad++;
      end
    end
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    i_reset = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
    valid3 = 1'b0; src3 = '0; dst3 = '0; imm_en3 = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    test_reset();
    test_reg_move();
    test_immediate();
    test_illegal();
    test_back_to_back();
    test_reset_mid_xfer();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
